// File: rtl/vco_pq_pkg.sv
// Shared constants and the ring-state to phase mapping for the VCO phase quantizer.
// Pure combinational helpers; no latency and no flow control of their own.
package vco_pq_pkg;

  localparam int NSTAGE = 32;
  localparam int PH_W   = 6;

  localparam logic [NSTAGE-1:0] ODD_MASK = 32'hAAAA_AAAA;

  typedef logic [PH_W-1:0] phase_t;

  // Popcount keeps the decode tolerant of thermometer bubbles; t[0] selects the half-period.
  function automatic phase_t phase_of(input logic [NSTAGE-1:0] t);
    phase_t c;
    c = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      c = c + PH_W'(t[i]);
    end
    phase_of = t[0] ? c : -c;
  endfunction

endpackage

// File: rtl/vco_phase_decode.sv
// Registered normalize/popcount/map of synchronized ring phases plus differential check.
// Latency 1 cycle; valid-only streaming, no backpressure.
module vco_phase_decode
  import vco_pq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vld,
  input  logic [NSTAGE-1:0] i_p,
  input  logic [NSTAGE-1:0] i_m,
  output phase_t            o_phase,
  output logic              o_vld,
  output logic              o_diff_err
);

  logic [NSTAGE-1:0] w_t;
  logic              w_err;

  phase_t r_phase;
  logic   r_vld;
  logic   r_err;

  assign w_t   = i_p ^ ODD_MASK;
  // A healthy differential pair always disagrees; any equal pair flags the sample.
  assign w_err = |(~(i_p ^ i_m));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_phase <= phase_of(w_t);
      r_vld   <= i_vld;
      r_err   <= w_err;
    end
  end

  assign o_phase    = r_phase;
  assign o_vld      = r_vld;
  assign o_diff_err = r_err;

endmodule

// File: rtl/vco_phase_quantizer.sv
// VCO ring reader: sync chain, phase decode, per-sample phase advance and windowed frequency sum.
// phase_q at SYNC_STAGES+1, dphase_q +1, freq_q +1 cycles; valid-only, no backpressure.
module vco_phase_quantizer
  import vco_pq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WIN_LOG2    = 4,
  parameter int FREQ_W      = PH_W + WIN_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NSTAGE-1:0] out_vco_p,
  input  logic [NSTAGE-1:0] out_vco_m,
  output logic [PH_W-1:0]   phase_q,
  output logic              phase_vld,
  output logic [PH_W-1:0]   dphase_q,
  output logic              dphase_vld,
  output logic [FREQ_W-1:0] freq_q,
  output logic              freq_vld,
  output logic              diff_err
);

  logic [NSTAGE-1:0]    r_p_sync [SYNC_STAGES];
  logic [NSTAGE-1:0]    r_m_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] r_en_sync;

  phase_t w_phase;
  logic   w_phase_vld;
  logic   w_diff_err;

  phase_t r_prev;
  logic   r_prev_vld;
  phase_t r_dphase;
  logic   r_dphase_vld;

  logic [WIN_LOG2-1:0] r_cnt;
  logic [FREQ_W-1:0]   r_acc;
  logic [FREQ_W-1:0]   r_freq;
  logic                r_freq_vld;

  // en rides the same number of flops so it stays aligned with the sampled phases.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_p_sync[i] <= '0;
        r_m_sync[i] <= '0;
      end
      r_en_sync <= '0;
    end else begin
      r_p_sync[0] <= out_vco_p;
      r_m_sync[0] <= out_vco_m;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_p_sync[i] <= r_p_sync[i-1];
        r_m_sync[i] <= r_m_sync[i-1];
      end
      r_en_sync <= {r_en_sync[SYNC_STAGES-2:0], en};
    end
  end

  vco_phase_decode u_decode (
    .clk        (clk),
    .rst        (rst),
    .i_vld      (r_en_sync[SYNC_STAGES-1]),
    .i_p        (r_p_sync[SYNC_STAGES-1]),
    .i_m        (r_m_sync[SYNC_STAGES-1]),
    .o_phase    (w_phase),
    .o_vld      (w_phase_vld),
    .o_diff_err (w_diff_err)
  );

  // First valid phase after a gap only seeds prev; 6-bit subtraction handles wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev       <= '0;
      r_prev_vld   <= 1'b0;
      r_dphase     <= '0;
      r_dphase_vld <= 1'b0;
    end else begin
      r_dphase_vld <= 1'b0;
      if (w_phase_vld) begin
        r_prev     <= w_phase;
        r_prev_vld <= 1'b1;
        if (r_prev_vld) begin
          r_dphase     <= w_phase - r_prev;
          r_dphase_vld <= 1'b1;
        end
      end else begin
        r_prev_vld <= 1'b0;
      end
    end
  end

  // Any break in the dphase stream discards the partial window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_freq     <= '0;
      r_freq_vld <= 1'b0;
    end else begin
      r_freq_vld <= 1'b0;
      if (r_dphase_vld) begin
        if (&r_cnt) begin
          r_freq     <= r_acc + FREQ_W'(r_dphase);
          r_freq_vld <= 1'b1;
          r_acc      <= '0;
          r_cnt      <= '0;
        end else begin
          r_acc <= r_acc + FREQ_W'(r_dphase);
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_acc <= '0;
        r_cnt <= '0;
      end
    end
  end

  assign phase_q    = w_phase;
  assign phase_vld  = w_phase_vld;
  assign diff_err   = w_diff_err;
  assign dphase_q   = r_dphase;
  assign dphase_vld = r_dphase_vld;
  assign freq_q     = r_freq;
  assign freq_vld   = r_freq_vld;

endmodule

// File: tb/tb_vco_phase_quantizer.sv
// Scoreboard bench: the driver queues expected phase/dphase/freq, a negedge monitor pops and compares.
module tb_vco_phase_quantizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [31:0] vp  = '0;
  logic [31:0] vm  = '1;
  logic [5:0]  phase_q;
  logic        phase_vld;
  logic [5:0]  dphase_q;
  logic        dphase_vld;
  logic [9:0]  freq_q;
  logic        freq_vld;
  logic        diff_err;

  vco_phase_quantizer dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .out_vco_p  (vp),
    .out_vco_m  (vm),
    .phase_q    (phase_q),
    .phase_vld  (phase_vld),
    .dphase_q   (dphase_q),
    .dphase_vld (dphase_vld),
    .freq_q     (freq_q),
    .freq_vld   (freq_vld),
    .diff_err   (diff_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int v;
    int e;
    int c;
  } exp_t;

  exp_t q_ph[$];
  exp_t q_dp[$];
  int   q_fr[$];

  int checks   = 0;
  int failures = 0;
  int n_freq   = 0;
  int last_freq = -1;

  int m_prev = 0;
  bit m_pv   = 1'b0;
  int m_cnt  = 0;
  int m_acc  = 0;

  function automatic void chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, req, cyc);
    end
  endfunction

  function automatic logic [31:0] therm(int k);
    logic [31:0] one;
    one = 32'd1;
    if (k == 0)       return 32'd0;
    else if (k == 32) return '1;
    else if (k < 32)  return (one << k) - 1;
    else              return ~((one << (k - 32)) - 1);
  endfunction

  task automatic drive(logic [31:0] t, int k, bit e, bit err);
    int d;
    vp = t ^ 32'hAAAA_AAAA;
    vm = ~vp;
    if (err) vm[7] = vp[7];
    en = e;
    if (e) begin
      q_ph.push_back('{k, int'(err), cyc});
      if (m_pv) begin
        d = (k - m_prev) & 63;
        q_dp.push_back('{d, 0, cyc});
        if (m_cnt == 15) begin
          q_fr.push_back(m_acc + d);
          m_acc = 0;
          m_cnt = 0;
        end else begin
          m_acc = m_acc + d;
          m_cnt = m_cnt + 1;
        end
      end else begin
        m_acc = 0;
        m_cnt = 0;
      end
      m_prev = k;
      m_pv   = 1'b1;
    end else begin
      m_pv  = 1'b0;
      m_acc = 0;
      m_cnt = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(32'd0, 0, 1'b0, 1'b0);
  endtask

  task automatic ramp(int n);
    for (int i = 0; i < n; i++) drive(therm((3 * i) & 63), (3 * i) & 63, 1'b1, 1'b0);
  endtask

  task automatic reset_seq(int n, int k);
    rst = 1'b1;
    vp  = therm(k) ^ 32'hAAAA_AAAA;
    vm  = ~vp;
    en  = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("rst_phase_vld", int'(phase_vld), 0);
      chk("rst_dphase_vld", int'(dphase_vld), 0);
      chk("rst_freq_vld", int'(freq_vld), 0);
    end
    chk("rst_phase_q", int'(phase_q), 0);
    chk("rst_dphase_q", int'(dphase_q), 0);
    chk("rst_freq_q", int'(freq_q), 0);
    chk("rst_diff_err", int'(diff_err), 0);
    q_ph.delete();
    q_dp.delete();
    q_fr.delete();
    m_pv  = 1'b0;
    m_acc = 0;
    m_cnt = 0;
    rst   = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (phase_vld) begin
      if (q_ph.size() == 0) chk("phase_unexpected", 1, 0);
      else begin
        x = q_ph.pop_front();
        chk("phase_q", int'(phase_q), x.v);
        chk("diff_err", int'(diff_err), x.e);
        chk("phase_latency", cyc - x.c, 3);
      end
    end
    if (dphase_vld) begin
      if (q_dp.size() == 0) chk("dphase_unexpected", 1, 0);
      else begin
        x = q_dp.pop_front();
        chk("dphase_q", int'(dphase_q), x.v);
        chk("dphase_latency", cyc - x.c, 4);
      end
    end
    if (freq_vld) begin
      n_freq++;
      last_freq = int'(freq_q);
      if (q_fr.size() == 0) chk("freq_unexpected", 1, 0);
      else chk("freq_q", int'(freq_q), q_fr.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    // Reset with a static phase 5 present, then stream it.
    #1;
    reset_seq(2, 5);
    for (int i = 0; i < 5; i++) drive(therm(5), 5, 1'b1, 1'b0);
    idle(2);

    // +3 per sample, 17 samples: one window of 16 advances of 3.
    n0 = n_freq;
    ramp(17);
    idle(6);
    chk("t2_freq_count", n_freq - n0, 1);
    chk("t2_freq_val", last_freq, 48);

    // Wrap-around and endpoint decodes.
    drive(therm(60), 60, 1'b1, 1'b0);
    drive(therm(62), 62, 1'b1, 1'b0);
    drive(therm(1), 1, 1'b1, 1'b0);
    drive(therm(4), 4, 1'b1, 1'b0);
    drive(therm(32), 32, 1'b1, 1'b0);
    drive(therm(33), 33, 1'b1, 1'b0);
    drive(therm(63), 63, 1'b1, 1'b0);
    drive(therm(0), 0, 1'b1, 1'b0);
    idle(2);

    // Bubble in the thermometer: bits 0,1,3 set.
    drive(32'h0000_000B, 3, 1'b1, 1'b0);
    // Single-cycle differential error on stage 7.
    drive(therm(10), 10, 1'b1, 1'b0);
    drive(therm(10), 10, 1'b1, 1'b1);
    drive(therm(10), 10, 1'b1, 1'b0);
    drive(therm(10), 10, 1'b1, 1'b0);
    idle(2);

    // en drop mid-window discards the partial window.
    n0 = n_freq;
    ramp(10);
    idle(1);
    ramp(17);
    idle(6);
    chk("t6_en_freq_count", n_freq - n0, 1);
    chk("t6_en_freq_val", last_freq, 48);

    // rst mid-window behaves the same way.
    n0 = n_freq;
    ramp(10);
    reset_seq(2, 0);
    ramp(17);
    idle(6);
    chk("t6_rst_freq_count", n_freq - n0, 1);
    chk("t6_rst_freq_val", last_freq, 48);

    chk("phase_queue_drained", q_ph.size(), 0);
    chk("dphase_queue_drained", q_dp.size(), 0);
    chk("freq_queue_drained", q_fr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
